counter_bounded: RTL and testbench

//  Parametrised up/down counter, successor to the basic counter. Counts between COUNT_START and

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_prescaler.sv | 38 +++
 rtl/counter_bounded.sv | 168 ++++++++++++++++
 tb/tb_counter_bounded.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared definitions for the bounded counter family
// Purpose: end-of-range mode encoding used by counter_bounded and its users.
// Ports: none (package).
package counter_pkg;

  // Selects what happens when a step would leave [COUNT_START, COUNT_END].
  typedef enum logic [1:0] {
    CNT_MODE_WRAP    = 2'd0,
    CNT_MODE_SAT     = 2'd1,
    CNT_MODE_ONESHOT = 2'd2
  } cnt_mode_t;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable prescaler producing one tick per PRESCALE enabled cycles
// Purpose: divides the count enable so the counter steps once every PRESCALE en-qualified edges.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset, clears the prescale count
//   en       in  advances the prescale count; en=0 pauses it
//   sync_clr in  synchronous clear of the prescale count (has priority over en)
//   tick     out combinational; high when en=1 and the count is at PRESCALE-1
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  // PRESCALE=1 still needs a 1-bit register; it simply stays at 0 so tick follows en.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/counter_bounded.sv
// rtl/counter_bounded.sv - bounded up/down counter with wrap/saturate/one-shot end-of-range modes
// Purpose: timer/index generator counting by STEP between COUNT_START and COUNT_END with a
//          prescaled enable, clamped load and boundary/terminal-count flags.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   en       in  count enable (through the prescaler)
//   dir      in  1 = up, 0 = down
//   clr      in  synchronous clear to COUNT_START; clears done and the prescaler
//   load     in  synchronous load of loadval (clamped); clears done and the prescaler
//   loadval  in  value to load
//   dataOut  out current count (registered)
//   tc       out one-cycle pulse showing the post-boundary value
//   done     out one-shot finished (ONESHOT mode only)
//   at_max   out dataOut == COUNT_END
//   at_min   out dataOut == COUNT_START
module counter_bounded
  import counter_pkg::*;
#(
  parameter int        DATA_WIDTH  = 8,
  parameter int        COUNT_START = 0,
  parameter int        COUNT_END   = (1 << DATA_WIDTH) - 1,
  parameter int        STEP        = 1,
  parameter cnt_mode_t MODE        = CNT_MODE_WRAP,
  parameter int        PRESCALE    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadval,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  tc,
  output logic                  done,
  output logic                  at_max,
  output logic                  at_min
);

  if (!(COUNT_START < COUNT_END && COUNT_END < (1 << DATA_WIDTH))) begin : g_chk_range
    $error("counter_bounded: need COUNT_START < COUNT_END < 2**DATA_WIDTH");
  end
  if (!(STEP >= 1 && STEP <= COUNT_END - COUNT_START + 1)) begin : g_chk_step
    $error("counter_bounded: need 1 <= STEP <= COUNT_END-COUNT_START+1");
  end
  if (PRESCALE < 1) begin : g_chk_prescale
    $error("counter_bounded: need PRESCALE >= 1");
  end
  if (MODE != CNT_MODE_WRAP && MODE != CNT_MODE_SAT && MODE != CNT_MODE_ONESHOT) begin : g_chk_mode
    $error("counter_bounded: illegal MODE");
  end

  // One extra bit so up-steps past 2**DATA_WIDTH-1 are still seen as boundary events.
  localparam int W1 = DATA_WIDTH + 1;
  localparam logic [W1-1:0] START_X = W1'(COUNT_START);
  localparam logic [W1-1:0] END_X   = W1'(COUNT_END);
  localparam logic [W1-1:0] STEP_X  = W1'(STEP);
  localparam logic [W1-1:0] N_X     = W1'(COUNT_END - COUNT_START + 1);
  localparam logic [DATA_WIDTH-1:0] START_V = DATA_WIDTH'(COUNT_START);
  localparam logic [DATA_WIDTH-1:0] END_V   = DATA_WIDTH'(COUNT_END);

  logic                  tick;
  logic [W1-1:0]         cur_x;
  logic [W1-1:0]         up_sum;
  logic [W1-1:0]         lv_x;
  logic                  bnd;
  logic                  nxt_tc;
  logic [DATA_WIDTH-1:0] nxt;
  logic [DATA_WIDTH-1:0] load_v;
  logic                  step_ok;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_clr(clr | load),
    .tick    (tick)
  );

  assign cur_x  = {1'b0, dataOut};
  assign up_sum = cur_x + STEP_X;
  assign lv_x   = {1'b0, loadval};

  always_comb begin
    if (lv_x > END_X)        load_v = END_V;
    else if (lv_x < START_X) load_v = START_V;
    else                     load_v = loadval;
  end

  always_comb begin
    bnd    = 1'b0;
    nxt_tc = 1'b0;
    nxt    = dataOut;
    if (dir) begin
      bnd = (up_sum > END_X);
      if (!bnd) begin
        nxt = DATA_WIDTH'(up_sum);
      end else begin
        case (MODE)
          CNT_MODE_WRAP: begin
            nxt    = DATA_WIDTH'(up_sum - N_X);
            nxt_tc = 1'b1;
          end
          CNT_MODE_SAT: begin
            nxt    = END_V;
            nxt_tc = (dataOut != END_V);
          end
          default: begin
            nxt    = END_V;
            nxt_tc = 1'b1;
          end
        endcase
      end
    end else begin
      bnd = (cur_x < START_X + STEP_X);
      if (!bnd) begin
        nxt = DATA_WIDTH'(cur_x - STEP_X);
      end else begin
        case (MODE)
          CNT_MODE_WRAP: begin
            // Add N before subtracting STEP so the intermediate never underflows.
            nxt    = DATA_WIDTH'(cur_x + N_X - STEP_X);
            nxt_tc = 1'b1;
          end
          CNT_MODE_SAT: begin
            nxt    = START_V;
            nxt_tc = (dataOut != START_V);
          end
          default: begin
            nxt    = START_V;
            nxt_tc = 1'b1;
          end
        endcase
      end
    end
  end

  // A finished one-shot ignores ticks until clr/load/rst restarts it.
  assign step_ok = tick && !((MODE == CNT_MODE_ONESHOT) && done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut <= START_V;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        dataOut <= START_V;
        done    <= 1'b0;
      end else if (load) begin
        dataOut <= load_v;
        done    <= 1'b0;
      end else if (step_ok) begin
        dataOut <= nxt;
        tc      <= nxt_tc;
        if ((MODE == CNT_MODE_ONESHOT) && bnd) done <= 1'b1;
      end
    end
  end

  assign at_max = (dataOut == END_V);
  assign at_min = (dataOut == START_V);

endmodule

// File: tb/tb_counter_bounded.sv
// tb/tb_counter_bounded.sv - scoreboard bench for counter_bounded
module tb_counter_bounded;
  import counter_pkg::*;

  localparam int W = 0;  // wrap instance
  localparam int S = 1;  // saturate instance
  localparam int O = 2;  // one-shot instance
  localparam int P = 3;  // PRESCALE=4, STEP=1 wrap instance

  typedef struct {
    int         id;
    logic [3:0] d;
    logic       tc;
    logic       done;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] loadval = 4'd0;

  logic [3:0] d_o    [4];
  logic       tc_o   [4];
  logic       done_o [4];
  logic       amax_o [4];
  logic       amin_o [4];

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  event chk_ev;

  always #5 clk = ~clk;

  counter_bounded #(.DATA_WIDTH(4), .COUNT_START(2), .COUNT_END(9), .STEP(3),
                    .MODE(CNT_MODE_WRAP), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load), .loadval(loadval),
    .dataOut(d_o[0]), .tc(tc_o[0]), .done(done_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0]));

  counter_bounded #(.DATA_WIDTH(4), .COUNT_START(2), .COUNT_END(9), .STEP(3),
                    .MODE(CNT_MODE_SAT), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load), .loadval(loadval),
    .dataOut(d_o[1]), .tc(tc_o[1]), .done(done_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1]));

  counter_bounded #(.DATA_WIDTH(4), .COUNT_START(2), .COUNT_END(9), .STEP(3),
                    .MODE(CNT_MODE_ONESHOT), .PRESCALE(1)) u_one (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load), .loadval(loadval),
    .dataOut(d_o[2]), .tc(tc_o[2]), .done(done_o[2]), .at_max(amax_o[2]), .at_min(amin_o[2]));

  counter_bounded #(.DATA_WIDTH(4), .COUNT_START(2), .COUNT_END(9), .STEP(1),
                    .MODE(CNT_MODE_WRAP), .PRESCALE(4)) u_pre (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load), .loadval(loadval),
    .dataOut(d_o[3]), .tc(tc_o[3]), .done(done_o[3]), .at_max(amax_o[3]), .at_min(amin_o[3]));

  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: samples 2 time units after being notified, away from any clock edge.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "dataOut", d_o[e.id], e.d);
        chk(e.name, "tc", {3'b0, tc_o[e.id]}, {3'b0, e.tc});
        chk(e.name, "done", {3'b0, done_o[e.id]}, {3'b0, e.done});
        chk(e.name, "at_max", {3'b0, amax_o[e.id]}, {3'b0, (e.d == 4'd9)});
        chk(e.name, "at_min", {3'b0, amin_o[e.id]}, {3'b0, (e.d == 4'd2)});
      end
    end
  end

  task automatic ex(input int id, input logic [3:0] d, input logic t, input logic dn, input string nm);
    exp_t e;
    e.id = id; e.d = d; e.tc = t; e.done = dn; e.name = nm;
    q.push_back(e);
    -> chk_ev;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across the first edge
    #7;
    for (int i = 0; i < 4; i++) ex(i, 4'd2, 1'b0, 1'b0, "reset");
    #5 rst = 1'b0;

    // WRAP
    loadval = 4'd8; load = 1'b1; step(); ex(W, 4'd8, 0, 0, "wrap_load8");
    load = 1'b0; en = 1'b1; dir = 1'b1; step(); ex(W, 4'd3, 1, 0, "wrap_up_bnd");
    en = 1'b0; step(); ex(W, 4'd3, 0, 0, "wrap_tc_1cyc");
    en = 1'b1; dir = 1'b0; step(); ex(W, 4'd8, 1, 0, "wrap_dn_bnd");
    step(); ex(W, 4'd5, 0, 0, "wrap_dn_step");
    en = 1'b0;

    // SAT
    loadval = 4'd8; load = 1'b1; step();
    load = 1'b0; en = 1'b1; dir = 1'b1; step(); ex(S, 4'd9, 1, 0, "sat_up_bnd");
    step(); ex(S, 4'd9, 0, 0, "sat_up_hold");
    en = 1'b0; loadval = 4'd4; load = 1'b1; step(); ex(S, 4'd4, 0, 0, "sat_load4");
    load = 1'b0; en = 1'b1; dir = 1'b0; step(); ex(S, 4'd2, 1, 0, "sat_dn_bnd");
    step(); ex(S, 4'd2, 0, 0, "sat_dn_hold");
    en = 1'b0;

    // ONESHOT
    loadval = 4'd7; load = 1'b1; step();
    load = 1'b0; en = 1'b1; dir = 1'b1; step(); ex(O, 4'd9, 1, 1, "one_bnd");
    repeat (5) begin step(); ex(O, 4'd9, 0, 1, "one_hold"); end
    dir = 1'b0; step(); ex(O, 4'd9, 0, 1, "one_dn_ignored");
    en = 1'b0; clr = 1'b1; step(); ex(O, 4'd2, 0, 0, "one_clr");
    clr = 1'b0;

    // Load clamping and priorities
    loadval = 4'd12; load = 1'b1; step(); ex(W, 4'd9, 0, 0, "load_hi_clamp");
    ex(S, 4'd9, 0, 0, "sat_load_no_tc");
    loadval = 4'd0; step(); ex(W, 4'd2, 0, 0, "load_lo_clamp");
    loadval = 4'd5; en = 1'b1; dir = 1'b1; step(); ex(W, 4'd5, 0, 0, "load_beats_en");
    clr = 1'b1; loadval = 4'd7; step(); ex(W, 4'd2, 0, 0, "clr_beats_load");
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // Prescaler
    clr = 1'b1; step(); ex(P, 4'd2, 0, 0, "pre_clr");
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      ex(P, (k < 4) ? 4'd2 : ((k < 8) ? 4'd3 : 4'd4), 0, 0, "pre_count");
    end
    en = 1'b0;
    repeat (2) begin step(); ex(P, 4'd4, 0, 0, "pre_pause"); end
    en = 1'b1; step(); ex(P, 4'd4, 0, 0, "pre_resume11");
    step(); ex(P, 4'd5, 0, 0, "pre_resume12");

    // Async reset mid-count
    en = 1'b0; loadval = 4'd8; load = 1'b1; step();
    load = 1'b0; en = 1'b1; dir = 1'b1; step();
    ex(W, 4'd3, 1, 0, "pre_rst_wrap");
    ex(O, 4'd9, 1, 1, "pre_rst_one");
    ex(P, 4'd8, 0, 0, "pre_rst_pre");
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) ex(i, 4'd2, 1'b0, 1'b0, "async_rst");
    for (int k = 1; k <= 4; k++) begin
      step();
      ex(P, (k < 4) ? 4'd2 : 4'd3, 0, 0, "rst_full_prescale");
    end
    en = 1'b0;

    step();
    #10;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
